// File: rtl/base_pkg.sv
// rtl/base_pkg.sv - shared types and helpers for the round-robin mux
package base_pkg;

    localparam int max_ways = 16;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // Width of a source index; never below one bit.
    function automatic int sel_bits(input int ways);
        return (ways > 2) ? $clog2(ways) : 1;
    endfunction

    // First requester at or after ptr, wrapping. Unused upper request bits
    // are zero, so scanning modulo max_ways visits sources in the same order
    // as scanning modulo the real source count.
    function automatic logic [max_ways-1:0] rr_pick(
        input logic [max_ways-1:0] req,
        input logic [3:0]          ptr
    );
        logic [max_ways-1:0] gnt;
        logic                found;
        logic [3:0]          idx;
        gnt   = '0;
        found = 1'b0;
        for (int j = 0; j < max_ways; j++) begin
            idx = ptr + 4'(j);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/base_alatch.sv
// rtl/base_alatch.sv - one-deep registered valid/ready stage
module base_alatch #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_v,
    output logic             i_r,
    input  logic [width-1:0] i_d,
    output logic             o_v,
    input  logic             o_r,
    output logic [width-1:0] o_d
);

    logic             r_v;
    logic [width-1:0] r_d;

    // Accept whenever empty or draining this cycle, so load and drain overlap.
    assign i_r = ~r_v | o_r;
    assign o_v = r_v;
    assign o_d = r_d;

    // Holding register: load on handshake, clear once drained with no refill.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v <= 1'b0;
            r_d <= '0;
        end else if (i_v && i_r) begin
            r_v <= 1'b1;
            r_d <= i_d;
        end else if (o_r) begin
            r_v <= 1'b0;
        end
    end

endmodule

// File: rtl/base_rrmux.sv
// rtl/base_rrmux.sv - packet-aware round-robin arbiter and stream mux
module base_rrmux
    import base_pkg::*;
#(
    parameter int width     = 1,
    parameter int ways      = 2,
    parameter int sel_width = sel_bits(ways)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:ways-1]       i_v,
    output logic [0:ways-1]       i_r,
    input  logic [0:ways*width-1] i_d,
    input  logic [0:ways-1]       i_e,
    output logic                  o_v,
    input  logic                  o_r,
    output logic [0:width-1]      o_d,
    output logic                  o_e,
    output logic [0:sel_width-1]  o_s
);

    localparam int pay_width = width + 1 + sel_width;

    lock_state_t            r_state, w_state_nxt;
    logic [sel_width-1:0]   r_ptr, w_ptr_nxt;
    logic [sel_width-1:0]   r_lock_src, w_lock_src_nxt;
    logic [max_ways-1:0]    w_req, w_gnt;
    logic [sel_width-1:0]   w_win;
    logic [width-1:0]       w_win_d;
    logic                   w_win_e;
    logic                   w_ld, w_xfer;
    logic [pay_width-1:0]   w_pay_in, w_pay_out;

    // Candidate set: only the owning source while a packet is open.
    always_comb begin
        w_req = '0;
        if (r_state == LOCKED) begin
            w_req[r_lock_src] = i_v[r_lock_src];
        end else begin
            for (int k = 0; k < ways; k++) w_req[k] = i_v[k];
        end
        w_gnt = rr_pick(w_req, 4'(r_ptr));
    end

    // Encode the winner and steer its beat toward the output stage.
    always_comb begin
        w_win   = '0;
        w_win_d = '0;
        w_win_e = 1'b0;
        for (int k = 0; k < max_ways; k++) begin
            if (w_gnt[k]) w_win = sel_width'(k);
        end
        for (int k = 0; k < ways; k++) begin
            if (w_gnt[k]) begin
                w_win_d = i_d[k*width +: width];
                w_win_e = i_e[k];
            end
        end
    end

    // Ready only to the winner, only when the output stage can take a beat.
    always_comb begin
        i_r = '0;
        for (int k = 0; k < ways; k++) i_r[k] = w_gnt[k] & w_ld & ~reset;
    end

    assign w_xfer   = |(i_v & i_r);
    assign w_pay_in = {w_win_d, w_win_e, w_win};
    assign {o_d, o_e, o_s} = w_pay_out;

    // Lock and pointer update: end-of-packet releases the lock and rotates.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_lock_src_nxt = r_lock_src;
        if (w_xfer) begin
            if (w_win_e) begin
                w_state_nxt = UNLOCKED;
                w_ptr_nxt   = (w_win == sel_width'(ways - 1)) ? '0 : w_win + sel_width'(1);
            end else begin
                w_state_nxt    = LOCKED;
                w_lock_src_nxt = w_win;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= UNLOCKED;
            r_ptr      <= '0;
            r_lock_src <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_lock_src <= w_lock_src_nxt;
        end
    end

    base_alatch #(
        .width (pay_width)
    ) u_out (
        .clk   (clk),
        .reset (reset),
        .i_v   (w_xfer),
        .i_r   (w_ld),
        .i_d   (w_pay_in),
        .o_v   (o_v),
        .o_r   (o_r),
        .o_d   (w_pay_out)
    );

endmodule

// File: tb/tb_base_rrmux.sv
// tb/tb_base_rrmux.sv - self-checking bench for base_rrmux
module tb_base_rrmux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] in_v, in_e;
    logic [7:0] in_d [5];
    logic       in_or;

    logic [0:2]  a_v, a_r, a_e;
    logic [0:23] a_d;
    logic        a_ov, a_oe;
    logic [0:7]  a_od;
    logic [0:1]  a_os;

    logic [0:4]  b_v, b_r, b_e;
    logic [0:39] b_d;
    logic        b_ov, b_oe;
    logic [0:7]  b_od;
    logic [0:2]  b_os;

    always_comb begin
        a_v = '0; a_e = '0; a_d = '0;
        b_v = '0; b_e = '0; b_d = '0;
        for (int k = 0; k < 3; k++) begin
            a_v[k] = in_v[k]; a_e[k] = in_e[k]; a_d[k*8 +: 8] = in_d[k];
        end
        for (int k = 0; k < 5; k++) begin
            b_v[k] = in_v[k]; b_e[k] = in_e[k]; b_d[k*8 +: 8] = in_d[k];
        end
    end

    base_rrmux #(.width(8), .ways(3)) u_a (
        .clk(clk), .reset(rst), .i_v(a_v), .i_r(a_r), .i_d(a_d), .i_e(a_e),
        .o_v(a_ov), .o_r(in_or), .o_d(a_od), .o_e(a_oe), .o_s(a_os)
    );

    base_rrmux #(.width(8), .ways(5)) u_b (
        .clk(clk), .reset(rst), .i_v(b_v), .i_r(b_r), .i_d(b_d), .i_e(b_e),
        .o_v(b_ov), .o_r(in_or), .o_d(b_od), .o_e(b_oe), .o_s(b_os)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int sel   = 0;

    // reference model: arbitration rules stated directly
    int         m_n, m_ptr, m_src, m_s, exp_g;
    bit         m_lock, m_ov, m_ld;
    logic [7:0] m_d;
    logic       m_e;
    logic [4:0] exp_ir;

    logic [4:0] obs_ir;
    logic       obs_ov, obs_e;
    logic [7:0] obs_d;
    int         obs_s;

    task automatic sample();
        obs_ir = '0;
        if (sel == 0) begin
            for (int k = 0; k < 3; k++) obs_ir[k] = a_r[k];
            obs_ov = a_ov; obs_d = a_od; obs_e = a_oe; obs_s = int'(a_os);
        end else begin
            for (int k = 0; k < 5; k++) obs_ir[k] = b_r[k];
            obs_ov = b_ov; obs_d = b_od; obs_e = b_oe; obs_s = int'(b_os);
        end
    endtask

    task automatic model_predict();
        exp_g = -1;
        if (m_lock) begin
            if (in_v[m_src]) exp_g = m_src;
        end else begin
            for (int j = 0; j < m_n; j++) begin
                int k;
                k = (m_ptr + j) % m_n;
                if (exp_g < 0 && in_v[k]) exp_g = k;
            end
        end
        m_ld   = !m_ov || in_or;
        exp_ir = '0;
        if (!rst && m_ld && exp_g >= 0) exp_ir[exp_g] = 1'b1;
    endtask

    task automatic model_advance();
        if (rst) begin
            m_ptr = 0; m_lock = 0; m_src = 0; m_ov = 0;
        end else if (exp_g >= 0 && m_ld) begin
            m_ov = 1; m_d = in_d[exp_g]; m_e = in_e[exp_g]; m_s = exp_g;
            if (in_e[exp_g]) begin
                m_lock = 0; m_ptr = (exp_g + 1) % m_n;
            end else begin
                m_lock = 1; m_src = exp_g;
            end
        end else if (m_ov && in_or) begin
            m_ov = 0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        sample();
        model_predict();
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int s);
        sel = s;
        m_n = (s == 0) ? 3 : 5;
        rst = 1'b1; in_v = '0; in_e = '0; in_or = 1'b1;
        settle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0; m_n = 3;
        rst = 1'b1; in_v = 5'b11111; in_e = 5'b11111; in_or = 1'b1;
        for (int k = 0; k < 5; k++) in_d[k] = 8'($urandom);
        @(posedge clk); #1;
        settle();
        n_cmp++; if (a_r !== 3'b000) begin n_bad++; $display("FAIL reset_ir_a: got %b want 000", a_r); end
        n_cmp++; if (b_r !== 5'b00000) begin n_bad++; $display("FAIL reset_ir_b: got %b want 00000", b_r); end
        n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL reset_ov_a: got %b want 0", a_ov); end
        n_cmp++; if (b_ov !== 1'b0) begin n_bad++; $display("FAIL reset_ov_b: got %b want 0", b_ov); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset(0);
        in_v = 5'b00111; in_e = 5'b11111; in_or = 1'b1;
        for (int k = 0; k < 5; k++) in_d[k] = 8'h10 + 8'(k);
        for (int c = 0; c < 7; c++) begin
            settle();
            n_cmp++; if (obs_ir !== exp_ir) begin n_bad++; $display("FAIL rr_ir c%0d: got %b want %b", c, obs_ir, exp_ir); end
            if (c >= 1) begin
                n_cmp++; if (obs_ov !== 1'b1) begin n_bad++; $display("FAIL rr_bubble c%0d: o_v %b want 1", c, obs_ov); end
                n_cmp++; if (obs_s != (c - 1) % 3) begin n_bad++; $display("FAIL rr_order c%0d: o_s %0d want %0d", c, obs_s, (c - 1) % 3); end
                n_cmp++; if (obs_d !== 8'h10 + 8'((c - 1) % 3)) begin n_bad++; $display("FAIL rr_data c%0d: o_d %h want %h", c, obs_d, 8'h10 + 8'((c - 1) % 3)); end
            end
            tick();
        end
    endtask

    task automatic test_packet_lock();
        logic [4:0] sv [7];
        logic [4:0] se [7];
        int beats [$];
        int want [5];
        sv = '{5'b00001, 5'b00111, 5'b00111, 5'b00111, 5'b00101, 5'b00000, 5'b00000};
        se = '{5'b11111, 5'b11101, 5'b11101, 5'b11111, 5'b11111, 5'b11111, 5'b11111};
        want = '{0, 1, 1, 1, 2};
        do_reset(0);
        in_or = 1'b1;
        for (int k = 0; k < 5; k++) in_d[k] = 8'($urandom);
        for (int c = 0; c < 7; c++) begin
            in_v = sv[c]; in_e = se[c];
            settle();
            n_cmp++; if (obs_ir !== exp_ir) begin n_bad++; $display("FAIL lock_ir c%0d: got %b want %b", c, obs_ir, exp_ir); end
            if (obs_ov === 1'b1) beats.push_back(obs_s);
            tick();
        end
        n_cmp++; if (beats.size() != 5) begin n_bad++; $display("FAIL lock_count: got %0d beats want 5", beats.size()); end
        for (int i = 0; i < 5 && i < beats.size(); i++) begin
            n_cmp++; if (beats[i] != want[i]) begin n_bad++; $display("FAIL lock_order beat %0d: o_s %0d want %0d", i, beats[i], want[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held_d;
        int held_s;
        do_reset(0);
        in_v = 5'b00111; in_e = 5'b11111;
        for (int k = 0; k < 5; k++) in_d[k] = 8'($urandom);
        for (int c = 0; c < 8; c++) begin
            in_or = (c >= 2 && c <= 5) ? 1'b0 : 1'b1;
            settle();
            n_cmp++; if (obs_ir !== exp_ir) begin n_bad++; $display("FAIL bp_ir c%0d: got %b want %b", c, obs_ir, exp_ir); end
            if (c == 2) begin held_d = obs_d; held_s = obs_s; end
            if (c >= 2 && c <= 5) begin
                n_cmp++; if (obs_ir !== 5'b0) begin n_bad++; $display("FAIL bp_stall_ir c%0d: got %b want 00000", c, obs_ir); end
                n_cmp++; if (obs_ov !== 1'b1 || obs_d !== held_d || obs_s != held_s) begin
                    n_bad++; $display("FAIL bp_hold c%0d: v%b d%h s%0d want v1 d%h s%0d", c, obs_ov, obs_d, obs_s, held_d, held_s);
                end
            end
            if (c == 6) begin
                n_cmp++; if (obs_ir === 5'b0) begin n_bad++; $display("FAIL bp_release_ir: got %b want nonzero", obs_ir); end
            end
            if (c == 7) begin
                n_cmp++; if (obs_ov !== 1'b1 || obs_s != (held_s + 1) % 3) begin
                    n_bad++; $display("FAIL bp_next: v%b s%0d want v1 s%0d", obs_ov, obs_s, (held_s + 1) % 3);
                end
            end
            tick();
        end
    endtask

    task automatic test_lock_stall();
        do_reset(0);
        in_or = 1'b1;
        for (int k = 0; k < 5; k++) in_d[k] = 8'($urandom);
        for (int c = 0; c < 6; c++) begin
            in_v = (c == 0 || c == 4) ? 5'b00011 : 5'b00010;
            in_e = (c == 4) ? 5'b11111 : 5'b11110;
            settle();
            n_cmp++; if (obs_ir !== exp_ir) begin n_bad++; $display("FAIL stall_ir c%0d: got %b want %b", c, obs_ir, exp_ir); end
            if (c >= 1 && c <= 3) begin
                n_cmp++; if (obs_ir[1] !== 1'b0) begin n_bad++; $display("FAIL stall_src1 c%0d: i_r[1] %b want 0", c, obs_ir[1]); end
            end
            if (c == 4) begin
                n_cmp++; if (obs_ir !== 5'b00001) begin n_bad++; $display("FAIL stall_end: got %b want 00001", obs_ir); end
            end
            if (c == 5) begin
                n_cmp++; if (obs_ir !== 5'b00010) begin n_bad++; $display("FAIL stall_next: got %b want 00010", obs_ir); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset(0);
        for (int k = 0; k < 5; k++) in_d[k] = 8'($urandom);
        for (int c = 0; c < 6; c++) begin
            rst   = (c == 2 || c == 3);
            in_or = (c == 0 || c >= 4);
            in_v  = (c < 2) ? 5'b00100 : 5'b00111;
            in_e  = (c < 2) ? 5'b11011 : 5'b11111;
            settle();
            n_cmp++; if (obs_ir !== exp_ir) begin n_bad++; $display("FAIL rstmid_ir c%0d: got %b want %b", c, obs_ir, exp_ir); end
            if (c == 2) begin
                n_cmp++; if (obs_ov !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: o_v %b want 1", obs_ov); end
            end
            if (c == 3) begin
                n_cmp++; if (obs_ov !== 1'b0 || obs_ir !== 5'b0) begin n_bad++; $display("FAIL rstmid_clear: o_v %b i_r %b want 0 00000", obs_ov, obs_ir); end
            end
            if (c == 4) begin
                n_cmp++; if (obs_ir !== 5'b00001) begin n_bad++; $display("FAIL rstmid_first: i_r %b want 00001", obs_ir); end
            end
            if (c == 5) begin
                n_cmp++; if (obs_ov !== 1'b1 || obs_s != 0) begin n_bad++; $display("FAIL rstmid_out: v%b s%0d want v1 s0", obs_ov, obs_s); end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap5();
        int beats [$];
        do_reset(1);
        in_v = 5'b10001; in_e = 5'b11111; in_or = 1'b1;
        for (int k = 0; k < 5; k++) in_d[k] = 8'($urandom);
        for (int c = 0; c < 8; c++) begin
            settle();
            n_cmp++; if (obs_ir !== exp_ir) begin n_bad++; $display("FAIL wrap_ir c%0d: got %b want %b", c, obs_ir, exp_ir); end
            if (obs_ov === 1'b1) beats.push_back(obs_s);
            tick();
        end
        n_cmp++; if (beats.size() != 7) begin n_bad++; $display("FAIL wrap_count: got %0d want 7", beats.size()); end
        for (int i = 0; i < beats.size(); i++) begin
            n_cmp++; if (beats[i] != ((i % 2 == 0) ? 0 : 4)) begin
                n_bad++; $display("FAIL wrap_order beat %0d: o_s %0d want %0d", i, beats[i], (i % 2 == 0) ? 0 : 4);
            end
        end
    endtask

    task automatic test_random(input int s);
        logic [4:0] mask;
        do_reset(s);
        mask = (s == 0) ? 5'b00111 : 5'b11111;
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            in_v  = 5'($urandom) & mask;
            in_e  = 5'($urandom) | 5'($urandom);
            in_or = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 5; k++) in_d[k] = 8'($urandom);
            settle();
            n_cmp++; if (obs_ir !== exp_ir) begin n_bad++; $display("FAIL rand%0d_ir c%0d: got %b want %b", s, c, obs_ir, exp_ir); end
            n_cmp++; if (obs_ov !== m_ov) begin n_bad++; $display("FAIL rand%0d_ov c%0d: got %b want %b", s, c, obs_ov, m_ov); end
            if (m_ov) begin
                n_cmp++; if (obs_d !== m_d || obs_e !== m_e || obs_s != m_s) begin
                    n_bad++; $display("FAIL rand%0d_beat c%0d: d%h e%b s%0d want d%h e%b s%0d", s, c, obs_d, obs_e, obs_s, m_d, m_e, m_s);
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_v = '0; in_e = '0; in_or = 1'b1;
        for (int k = 0; k < 5; k++) in_d[k] = '0;
        m_n = 3; m_ptr = 0; m_src = 0; m_lock = 0; m_ov = 0; m_s = 0; m_d = '0; m_e = 1'b0;
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_lock_stall();
        test_reset_mid_packet();
        test_wrap5();
        test_random(0);
        test_random(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
